sd_spi_master: RTL and testbench
================================

Name: sd_spi_master

Overview:
- SPI mode-0 initiator for the SD-card bus. It is the other end of the sd_card SPI responder.
- The core side issues one byte per start strobe. The block shifts the byte out MSB-first on mosi and shifts the byte returned on miso into rx_byte.
- Chip select and the SCK rate (slow init / fast data) are under core control.
- It sits between the core's storage controller and the sd_card responder, all in the clk_sys domain.

Parameters:
CLK_DIV_SLOW, 62, SCK half-period minus 1 in clk_sys cycles when fast=0 (50 MHz -> ~397 kHz)
CLK_DIV_FAST, 1, SCK half-period minus 1 in clk_sys cycles when fast=1 (50 MHz -> 12.5 MHz)

Ports:
clk_sys   in   1  system clock; all logic on rising edge
reset_n   in   1  reset, synchronous, active-low
start     in   1  1-cycle request to transfer tx_byte; honoured only when busy=0
tx_byte   in   8  byte to send, captured on the accepting edge
fast      in   1  selects CLK_DIV_FAST (1) or CLK_DIV_SLOW (0), captured with start
cs_assert in   1  1 = drive ss_n low; takes effect only while busy=0
busy      out  1  high from the accepting edge until the transfer completes
done      out  1  1-cycle pulse when rx_byte is valid
rx_byte   out  8  last received byte, holds until next done
sck       out  1  SPI clock, idles low (CPOL=0)
mosi      out  1  SPI data out, idles high
miso      in   1  SPI data in, synchronous to clk_sys
ss_n      out  1  SPI select, active-low, registered

Behaviour:
- Clock and reset: one clock, clk_sys. reset_n is synchronous and active-low.
- Reset values while reset_n=0: sck=0, mosi=1, ss_n=1, busy=0, done=0, rx_byte=0x00, state=IDLE, all counters 0.
- Reset mid-transfer: abort at the next edge. sck returns to 0, no done pulse, no rx_byte update.
- Divider: D = captured divider value. Each SCK phase lasts exactly D+1 clk_sys cycles. Phase counter is 8 bits, counts 0..D, then wraps to 0.
- States: IDLE, SETUP (sck low), HIGH (sck high).
- IDLE:
  - sck=0, mosi=1, busy=0.
  - ss_n <= ~cs_assert every cycle.
  - start=1 on an edge:
    - capture tx_byte into the shift register;
    - D <= fast ? CLK_DIV_FAST : CLK_DIV_SLOW;
    - mosi <= tx_byte[7], bit counter <= 0;
    - busy <= 1, state <= SETUP.
- SETUP: after D+1 cycles, sck <= 1, state <= HIGH.
- HIGH:
  - In the last cycle of the phase, the miso value is shifted into the LSB of the receive shift register.
  - At phase end, sck <= 0.
  - If bit counter = 7:
    - rx_byte <= completed shift value;
    - done <= 1 for one cycle;
    - busy <= 0, mosi <= 1, state <= IDLE.
  - Otherwise: bit counter += 1, mosi <= next TX bit, state <= SETUP.
- Latency: with the accepting edge as cycle 0, done and busy=0 are visible after edge 16*(D+1). Exactly 8 SCK rising edges occur per byte.
- Bit order: MSB first in both directions. mosi is stable for the full SETUP+HIGH window of each bit.
- While busy=1:
  - start is ignored (not queued);
  - tx_byte, fast and cs_assert changes are ignored;
  - ss_n holds its value.
- Back-to-back: start asserted during the cycle done=1 (busy=0) is accepted. The inter-byte sck-low gap is then 1 cycle plus the next SETUP.
- done and start in the same cycle is legal. rx_byte keeps the just-completed value until the next done.
- Divider value 0: SCK = clk_sys/2, byte takes 16 cycles. Behaviour is otherwise identical.

Test Plan:
1. Reset: hold reset_n=0 mid-stream with start=1 -> sck=0, mosi=1, ss_n=1, busy=0, done=0, rx_byte=0x00; no SCK edges.
2. Fast loopback: miso tied to mosi, cs_assert=1, fast=1, D=1, start with 0xA5 -> ss_n=0, 8 rising sck edges, each phase 2 cycles; done at cycle 32 after accept; rx_byte=0xA5; mosi=1 afterwards.
3. Slow: fast=0, D=62, miso=1, send 0x00 -> sck half-period 63 cycles; done at cycle 1008; rx_byte=0xFF; mosi low throughout the byte.
4. Busy rules: pulse start with 0x3C at cycle 5 of a 0x81 transfer and toggle cs_assert to 0 -> only 0x81 appears on mosi; ss_n stays 0 until idle, then rises the cycle after idle.
5. Abort: reset_n=0 during bit 3 of a slow transfer -> next edge sck=0, busy=0, no done. A following transfer of 0x5A (loopback) returns 0x5A.
6. Back-to-back: assert start with 0x12 in the done cycle of a 0xF0 transfer (loopback, fast) -> second transfer accepted; sck stays low 3 cycles between bytes (1 gap + 2 SETUP); rx_byte=0xF0 then 0x12.

Source files
------------

// File: rtl/sd_spi_master.sv
// SPI mode-0 initiator for the SD-card bus: one byte per start strobe, MSB first,
// with a core-selectable slow (init) or fast (data) SCK divider.
module sd_spi_master #(
    parameter int unsigned CLK_DIV_SLOW = 62,
    parameter int unsigned CLK_DIV_FAST = 1
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] tx_byte,
    input  logic       fast,
    input  logic       cs_assert,
    output logic       busy,
    output logic       done,
    output logic [7:0] rx_byte,
    output logic       sck,
    output logic       mosi,
    input  logic       miso,
    output logic       ss_n
);

    localparam logic [7:0] DIV_SLOW = 8'(CLK_DIV_SLOW);
    localparam logic [7:0] DIV_FAST = 8'(CLK_DIV_FAST);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        HIGH  = 2'd2
    } state_t;

    state_t     state_q;
    logic [7:0] div_q;
    logic [7:0] phase_q;
    logic [2:0] bit_q;
    logic [7:0] tx_sr_q;
    logic [7:0] rx_sr_q;
    logic [7:0] rx_byte_q;
    logic       sck_q;
    logic       mosi_q;
    logic       ss_n_q;
    logic       busy_q;
    logic       done_q;
    logic       phase_end;

    assign phase_end = (phase_q == div_q);

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            div_q     <= 8'd0;
            phase_q   <= 8'd0;
            bit_q     <= 3'd0;
            tx_sr_q   <= 8'd0;
            rx_sr_q   <= 8'd0;
            rx_byte_q <= 8'd0;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b1;
            ss_n_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    sck_q   <= 1'b0;
                    mosi_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    phase_q <= 8'd0;
                    // chip select only follows the core between transfers
                    ss_n_q  <= ~cs_assert;
                    if (start) begin
                        tx_sr_q <= tx_byte;
                        div_q   <= fast ? DIV_FAST : DIV_SLOW;
                        mosi_q  <= tx_byte[7];
                        bit_q   <= 3'd0;
                        busy_q  <= 1'b1;
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    if (phase_end) begin
                        phase_q <= 8'd0;
                        sck_q   <= 1'b1;
                        state_q <= HIGH;
                    end else begin
                        phase_q <= phase_q + 8'd1;
                    end
                end
                HIGH: begin
                    if (phase_end) begin
                        phase_q <= 8'd0;
                        sck_q   <= 1'b0;
                        // miso is sampled in the final cycle of the high phase
                        rx_sr_q <= {rx_sr_q[6:0], miso};
                        if (bit_q == 3'd7) begin
                            rx_byte_q <= {rx_sr_q[6:0], miso};
                            done_q    <= 1'b1;
                            busy_q    <= 1'b0;
                            mosi_q    <= 1'b1;
                            state_q   <= IDLE;
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            mosi_q  <= tx_sr_q[6];
                            tx_sr_q <= {tx_sr_q[6:0], 1'b0};
                            state_q <= SETUP;
                        end
                    end else begin
                        phase_q <= phase_q + 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_byte = rx_byte_q;
    assign sck     = sck_q;
    assign mosi    = mosi_q;
    assign ss_n    = ss_n_q;

endmodule

// File: tb/tb_sd_spi_master.sv
// Scoreboard bench for sd_spi_master: stimulus pushes expected transfers, a
// negedge monitor checks bits on mosi, latency, SCK edge count and rx_byte.
module tb_sd_spi_master;

    localparam int DS = 62;
    localparam int DF = 1;

    logic       clk_sys = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] tx_byte = 8'h00;
    logic       fast = 1'b0;
    logic       cs_assert = 1'b0;
    logic       busy, done, sck, mosi, ss_n, miso;
    logic [7:0] rx_byte;
    logic [1:0] mode = 2'd0;

    sd_spi_master #(.CLK_DIV_SLOW(DS), .CLK_DIV_FAST(DF)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .start(start), .tx_byte(tx_byte),
        .fast(fast), .cs_assert(cs_assert), .busy(busy), .done(done),
        .rx_byte(rx_byte), .sck(sck), .mosi(mosi), .miso(miso), .ss_n(ss_n)
    );

    always #5 clk_sys = ~clk_sys;

    // miso sources: loopback, inverted loopback, constant 0, constant 1
    always_comb begin
        case (mode)
            2'd0:    miso = mosi;
            2'd1:    miso = ~mosi;
            2'd2:    miso = 1'b0;
            default: miso = 1'b1;
        endcase
    end

    typedef struct {
        logic [7:0] tx;
        logic [7:0] rx;
        int         acc;
        int         d;
    } exp_t;

    exp_t sbq[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   rises = 0;
    int   fall_cyc = 0;
    int   first_gap = 0;
    logic prev_sck = 1'b0;

    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic logic [7:0] ref_rx(input logic [7:0] b, input logic [1:0] m);
        case (m)
            2'd0:    return b;
            2'd1:    return ~b;
            2'd2:    return 8'h00;
            default: return 8'hFF;
        endcase
    endfunction

    // Monitor / scoreboard consumer
    always @(negedge clk_sys) begin
        exp_t       e;
        logic [7:0] txv;
        if (!reset_n) begin
            rises    = 0;
            prev_sck = 1'b0;
        end else begin
            if (sck && !prev_sck) begin
                if (rises == 0) first_gap = cyc - fall_cyc;
                if (sbq.size() == 0 || rises > 7) begin
                    check("sck_rise_unexpected", 1, 0);
                end else begin
                    txv = sbq[0].tx;
                    check("mosi_bit", int'(mosi), int'(txv[7 - rises]));
                    rises++;
                end
            end
            if (!sck && prev_sck) fall_cyc = cyc;
            if (!busy) begin
                check("idle_sck", int'(sck), 0);
                check("idle_mosi", int'(mosi), 1);
            end
            if (done) begin
                if (sbq.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    check("rx_byte", int'(rx_byte), int'(e.rx));
                    check("done_latency", cyc - e.acc, 16 * (e.d + 1));
                    check("sck_rises", rises, 8);
                end
                rises = 0;
            end
            prev_sck = sck;
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #2;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 3000) begin
            tick();
            n++;
        end
        if (busy) check("idle_timeout", 1, 0);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 20000) begin
            tick();
            n++;
        end
        if (!done) check("done_timeout", 1, 0);
    endtask

    task automatic send(input logic [7:0] b, input logic f);
        exp_t e;
        wait_idle();
        tx_byte = b;
        fast    = f;
        start   = 1'b1;
        e.tx  = b;
        e.rx  = ref_rx(b, mode);
        e.acc = cyc + 1;
        e.d   = f ? DF : DS;
        sbq.push_back(e);
        tick();
        start = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        int         n;

        // 1. reset held with start asserted
        reset_n   = 1'b0;
        start     = 1'b1;
        tx_byte   = 8'hA5;
        cs_assert = 1'b1;
        fast      = 1'b1;
        repeat (6) begin
            tick();
            check("rst_sck", int'(sck), 0);
        end
        check("rst_mosi", int'(mosi), 1);
        check("rst_ss_n", int'(ss_n), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_rx", int'(rx_byte), 0);
        start   = 1'b0;
        reset_n = 1'b1;
        tick();

        // 2. fast loopback
        mode = 2'd0;
        send(8'hA5, 1'b1);
        check("t2_ss_n_low", int'(ss_n), 0);
        wait_done();
        check("t2_rx", int'(rx_byte), 8'hA5);
        tick();
        check("t2_mosi_after", int'(mosi), 1);

        // 3. slow, miso held high
        mode = 2'd3;
        send(8'h00, 1'b0);
        wait_done();
        check("t3_rx", int'(rx_byte), 8'hFF);
        tick();

        // 4. busy rules: start and cs_assert ignored mid-transfer
        mode = 2'd0;
        send(8'h81, 1'b1);
        repeat (3) tick();
        tx_byte   = 8'h3C;
        start     = 1'b1;
        cs_assert = 1'b0;
        tick();
        start = 1'b0;
        check("t4_ss_n_held", int'(ss_n), 0);
        wait_done();
        check("t4_rx", int'(rx_byte), 8'h81);
        check("t4_ss_n_done", int'(ss_n), 0);
        tick();
        check("t4_ss_n_rise", int'(ss_n), 1);
        repeat (40) tick();
        check("t4_no_queued", int'(busy), 0);
        cs_assert = 1'b1;
        tick();

        // 5. abort mid slow transfer
        mode = 2'd0;
        send(8'hC3, 1'b0);
        n = 0;
        while (rises < 4 && n < 5000) begin
            tick();
            n++;
        end
        check("t5_reached_bit3", int'(rises >= 4), 1);
        reset_n = 1'b0;
        sbq.delete();
        tick();
        check("t5_sck", int'(sck), 0);
        check("t5_busy", int'(busy), 0);
        check("t5_done", int'(done), 0);
        check("t5_rx", int'(rx_byte), 0);
        reset_n = 1'b1;
        repeat (3) tick();
        check("t5_no_done", int'(done), 0);
        send(8'h5A, 1'b1);
        wait_done();
        check("t5_rx_after", int'(rx_byte), 8'h5A);
        tick();

        // 6. back-to-back in the done cycle
        send(8'hF0, 1'b1);
        wait_done();
        send(8'h12, 1'b1);
        check("t6_rx_hold", int'(rx_byte), 8'hF0);
        check("t6_busy", int'(busy), 1);
        wait_done();
        check("t6_rx_second", int'(rx_byte), 8'h12);
        check("t6_gap", first_gap, 3);
        tick();

        // Randomized transfers
        for (int i = 0; i < 24; i++) begin
            mode      = 2'($urandom_range(0, 3));
            cs_assert = 1'($urandom_range(0, 1));
            b         = 8'($urandom);
            send(b, (i % 8 == 3) ? 1'b0 : 1'b1);
            wait_done();
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 4)) tick();
        end
        wait_idle();
        repeat (5) tick();
        check("sb_empty", sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
